// File: rtl/shape_processor_pkg.sv
// Shared types and legality rules for the shape processor (control SFR block and compute engine).
package shape_processor_pkg;

    typedef enum logic [2:0] {
        KEEP_SHAPE = 3'd0,
        SQUARE     = 3'd1,
        RECTANGLE  = 3'd2,
        TRIANGLE   = 3'd3
    } shape_t;

    typedef enum logic [1:0] {
        KEEP_OPERATION = 2'd0,
        AREA           = 2'd1,
        PERIMETER      = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } calc_state_e;

    function automatic logic is_legal_shape(input shape_t shape);
        return (shape == SQUARE) || (shape == RECTANGLE) || (shape == TRIANGLE);
    endfunction

    function automatic logic is_legal_operation(input op_t op);
        return (op == AREA) || (op == PERIMETER);
    endfunction

    // KEEP_* codes are only meaningful to the SFR block, so they fail here too.
    function automatic logic is_legal_combination(input shape_t shape, input op_t op);
        return is_legal_shape(shape) && is_legal_operation(op) &&
               !((shape == TRIANGLE) && (op == PERIMETER));
    endfunction

endpackage

// File: rtl/shape_calc_mul.sv
// Serial shift-add multiplier: one multiplier bit per cycle, LSB first, WIDTH cycles after start.
module shape_calc_mul
    import shape_processor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = 2 * WIDTH;

    logic            r_run;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_acc;
    logic [RW-1:0]   r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [RW-1:0]   w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // product includes the final iteration so the caller can capture it on the done cycle.
    assign done    = r_run && (r_cnt == CW'(WIDTH - 1));
    assign product = w_acc_next;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= RW'(multiplicand);
            r_mplier <= multiplier;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shape_calc_engine.sv
// Shape compute engine: accepts one command, computes area (serial multiply) or perimeter,
// and holds the result or an error flag on a valid/ready result port.
module shape_calc_engine
    import shape_processor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  shape_t               cmd_shape,
    input  op_t                  cmd_op,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 res_err,
    output logic                 busy
);

    localparam int RW = 2 * WIDTH;

    calc_state_e     r_state;
    calc_state_e     w_state_next;
    shape_t          r_shape;
    logic [RW-1:0]   r_res_data;
    logic            r_res_err;

    logic            w_accept;
    logic            w_legal;
    logic            w_is_area;
    logic            w_mul_start;
    logic            w_mul_done;
    logic [RW-1:0]   w_product;
    logic [WIDTH:0]  w_sum;
    logic [RW-1:0]   w_perim;

    assign w_accept    = cmd_valid && (r_state == IDLE);
    assign w_legal     = is_legal_combination(cmd_shape, cmd_op);
    assign w_is_area   = (cmd_op == AREA);
    assign w_mul_start = w_accept && w_legal && w_is_area;
    assign w_sum       = {1'b0, cmd_a} + {1'b0, cmd_b};

    always_comb begin
        w_perim = '0;
        case (cmd_shape)
            SQUARE:    w_perim = RW'({cmd_a, 2'b00});
            RECTANGLE: w_perim = RW'({w_sum, 1'b0});
            default:   w_perim = '0;
        endcase
    end

    shape_calc_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (w_mul_start),
        .multiplicand (cmd_a),
        .multiplier   ((cmd_shape == SQUARE) ? cmd_a : cmd_b),
        .done         (w_mul_done),
        .product      (w_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_next = w_mul_start ? MUL : DONE;
            MUL:     if (w_mul_done) w_state_next = DONE;
            DONE:    if (res_ready)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Result is written only at accept or at the end of MUL, so it cannot move while held in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shape    <= KEEP_SHAPE;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else if (w_accept) begin
            r_shape    <= cmd_shape;
            r_res_err  <= !w_legal;
            r_res_data <= (w_legal && !w_is_area) ? w_perim : '0;
        end else if ((r_state == MUL) && w_mul_done) begin
            r_res_data <= (r_shape == TRIANGLE) ? (w_product >> 1) : w_product;
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign res_valid = (r_state == DONE);
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_shape_calc_engine.sv
// Directed and randomized checks of shape_calc_engine against a plain-arithmetic reference model.
module tb_shape_calc_engine;
    import shape_processor_pkg::*;

    localparam int WIDTH = 8;
    localparam int RW    = 2 * WIDTH;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    shape_t           cmd_shape = KEEP_SHAPE;
    op_t              cmd_op    = KEEP_OPERATION;
    logic [WIDTH-1:0] cmd_a     = '0;
    logic [WIDTH-1:0] cmd_b     = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [RW-1:0]    res_data;
    logic             res_err;
    logic             busy;

    int n_vec  = 0;
    int n_fail = 0;

    shape_calc_engine #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_shape (cmd_shape),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: legality and arithmetic straight from the shape rules.
    task automatic model(input int s, input int o, input int a, input int b,
                         output logic err, output int data, output int lat);
        logic legal;
        legal = (s >= 1 && s <= 3) && (o == 1 || o == 2) && !(s == 3 && o == 2);
        err   = !legal;
        data  = 0;
        lat   = 1;
        if (legal && o == 1) begin
            lat = WIDTH + 1;
            if (s == 1)      data = a * a;
            else if (s == 2) data = a * b;
            else             data = (a * b) / 2;
        end else if (legal) begin
            if (s == 1) data = 4 * a;
            else        data = 2 * (a + b);
        end
    endtask

    task automatic send(input int s, input int o, input int a, input int b);
        cmd_shape = shape_t'(3'(s));
        cmd_op    = op_t'(2'(o));
        cmd_a     = WIDTH'(a);
        cmd_b     = WIDTH'(b);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called in the cycle after accept; counts cycles until res_valid (bounded).
    task automatic wait_result(input string tag, input logic e_err, input int e_data, input int e_lat);
        int c = 1;
        while (!res_valid && c < e_lat + 4) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
            c++;
        end
        check({tag, "_lat"}, 32'(c), 32'(e_lat));
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_data"}, 32'(res_data), 32'(e_data));
        check({tag, "_err"}, 32'(res_err), 32'(e_err));
        check({tag, "_noready"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic run_cmd(input string tag, input int s, input int o, input int a, input int b);
        logic e_err;
        int   e_data;
        int   e_lat;
        model(s, o, a, b, e_err, e_data, e_lat);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        send(s, o, a, b);
        wait_result(tag, e_err, e_data, e_lat);
        tick();
        check({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        logic e_err;
        int   e_data;
        int   e_lat;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data",  32'(res_data),  32'd0);
        check("rst_err",   32'(res_err),   32'd0);
        check("rst_busy",  32'(busy),      32'd0);

        // Area, including all-ones operands and triangle floor
        run_cmd("rect_area", 2, 1, 12, 10);
        run_cmd("sq_area_max", 1, 1, 255, 0);
        run_cmd("tri_area", 3, 1, 7, 5);
        run_cmd("rect_area_max", 2, 1, 255, 255);

        // Perimeter
        run_cmd("rect_perim", 2, 2, 3, 4);
        run_cmd("sq_perim_max", 1, 2, 255, 9);
        run_cmd("rect_perim_max", 2, 2, 255, 255);

        // Zero operands are legal
        run_cmd("zero_area", 2, 1, 0, 77);
        run_cmd("zero_perim", 2, 2, 0, 33);

        // Illegal requests
        run_cmd("tri_perim", 3, 2, 5, 6);
        run_cmd("op3", 2, 3, 5, 6);
        run_cmd("keep_shape", 0, 1, 5, 6);
        run_cmd("keep_op", 1, 0, 5, 6);
        run_cmd("shape7", 7, 1, 5, 6);

        // Back-pressure: result held, next command waits on the bus
        res_ready = 1'b0;
        check("bp_ready", 32'(cmd_ready), 32'd1);
        send(2, 2, 3, 4);
        cmd_shape = SQUARE;
        cmd_op    = AREA;
        cmd_a     = 8'd9;
        cmd_valid = 1'b1;
        check("bp_valid0", 32'(res_valid), 32'd1);
        check("bp_data0",  32'(res_data),  32'd14);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_valid%0d", i + 1), 32'(res_valid), 32'd1);
            check($sformatf("bp_data%0d", i + 1),  32'(res_data),  32'd14);
            check($sformatf("bp_err%0d", i + 1),   32'(res_err),   32'd0);
            check($sformatf("bp_cready%0d", i + 1), 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        check("bp_hs_ready", 32'(cmd_ready), 32'd1);
        check("bp_hs_valid", 32'(res_valid), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_busy", 32'(busy), 32'd1);
        wait_result("bp_next", 1'b0, 81, WIDTH + 1);
        tick();

        // Reset in the 4th MUL cycle aborts the operation
        check("abort_ready", 32'(cmd_ready), 32'd1);
        send(2, 1, 100, 200);
        repeat (3) tick();
        check("abort_in_mul", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready1", 32'(cmd_ready), 32'd1);
        check("abort_valid1", 32'(res_valid), 32'd0);
        check("abort_busy1",  32'(busy),      32'd0);
        repeat (WIDTH) begin
            tick();
            check("abort_noresult", 32'(res_valid), 32'd0);
        end
        run_cmd("after_abort", 2, 1, 2, 3);

        // Randomized commands against the reference model
        for (int i = 0; i < 60; i++) begin
            int s;
            int o;
            int a;
            int b;
            s = int'($urandom_range(0, 7));
            o = int'($urandom_range(0, 3));
            if (($urandom_range(0, 3) != 0) && s > 3) s = int'($urandom_range(1, 3));
            if ($urandom_range(0, 2) != 0 && (o == 0 || o == 3)) o = int'($urandom_range(1, 2));
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = 255;
            if ($urandom_range(0, 7) == 0) b = 0;
            model(s, o, a, b, e_err, e_data, e_lat);
            check($sformatf("rnd%0d_ready", i), 32'(cmd_ready), 32'd1);
            send(s, o, a, b);
            wait_result($sformatf("rnd%0d", i), e_err, e_data, e_lat);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
